// File: rtl/accel_seq_pkg.sv
// Shared types for the accel_seq micro-sequencer: opcodes, FSM states,
// bus register map and the packed program-slot format.
package accel_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] ADDR_R0   = 4'h0;
  localparam logic [3:0] ADDR_R1   = 4'h1;
  localparam logic [3:0] ADDR_R2   = 4'h2;
  localparam logic [3:0] ADDR_R3   = 4'h3;
  localparam logic [3:0] ADDR_CTRL = 4'h4;
  localparam logic [3:0] ADDR_LEN  = 4'h5;
  localparam logic [3:0] ADDR_ILO  = 4'h6;
  localparam logic [3:0] ADDR_IHI  = 4'h7;
  localparam logic [3:0] ADDR_WPTR = 4'h8;
  localparam logic [3:0] ADDR_PC   = 4'h9;
  localparam logic [3:0] ADDR_LOOP = 4'hA;

  typedef struct packed {
    logic [1:0] dst;
    logic [1:0] srcb;
    logic [1:0] srca;
    logic [3:0] op;
  } instr_t;

  // Opcodes outside this set execute as writeback NOPs and raise err.
  function automatic logic op_supported(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/accel_seq_if.sv
// Peripheral bus bundle between the host (master) and the sequencer (slave).
interface accel_seq_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/accel_seq_prog_mem.sv
// Program store: PROG_DEPTH packed instructions, synchronous write,
// asynchronous read, synchronous clear on rst.
module accel_seq_prog_mem
  import accel_seq_pkg::*;
#(
  parameter int PROG_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] i_waddr,
  input  instr_t                        i_wdata,
  input  logic [$clog2(PROG_DEPTH)-1:0] i_raddr,
  output instr_t                        o_rdata
);

  instr_t r_mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PROG_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/accel_seq_ctrl.sv
// Micro-sequencer running a stored ADD/SUB program over a 4-entry register
// file through an external ALU. Optional loop-count register via ACCEL_SEQ_LOOP_EN.
module accel_seq_ctrl
  import accel_seq_pkg::*;
#(
  parameter int PROG_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  accel_seq_if.slave        bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy,
  output logic              done
);

  localparam int PC_W  = $clog2(PROG_DEPTH);
  localparam int LEN_W = PC_W + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_rf [4];
  logic [LEN_W-1:0]  r_len;
  logic [7:0]        r_latch;
  logic [PC_W-1:0]   r_wptr;
  logic [PC_W-1:0]   r_pc;
  instr_t            r_instr;
  instr_t            w_slot;
  instr_t            w_commit;
  logic              r_err;
  logic              r_done_sticky;
  logic              w_wr_idle;
  logic              w_wr_ctrl;
  logic              w_abort;
  logic              w_start;
  logic              w_last;
  logic              w_loop_again;
  logic              w_launch;
  logic              w_fetch;
  logic              w_wb;
  logic              w_mem_we;
  logic [7:0]        w_loop_rd;

  function automatic logic [LEN_W-1:0] sat_len(input logic [7:0] v);
    if (v > 8'(PROG_DEPTH)) return LEN_W'(PROG_DEPTH);
    return LEN_W'(v);
  endfunction

  // Abort dominates start when both bits arrive in one control write.
  assign w_wr_ctrl = bus.data_write && (bus.address == ADDR_CTRL);
  assign w_abort   = w_wr_ctrl && bus.data_in[1];
  assign w_start   = w_wr_ctrl && bus.data_in[0] && !bus.data_in[1];
  assign w_wr_idle = bus.data_write && !busy;
  assign w_mem_we  = w_wr_idle && (bus.address == ADDR_IHI);
  assign w_commit  = instr_t'({bus.data_in[1:0], r_latch});
  assign w_last    = ({1'b0, r_pc} == (r_len - LEN_W'(1)));

  accel_seq_prog_mem #(
    .PROG_DEPTH(PROG_DEPTH)
  ) u_prog_mem (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_mem_we),
    .i_waddr(r_wptr),
    .i_wdata(w_commit),
    .i_raddr(r_pc),
    .o_rdata(w_slot)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_launch    = 1'b0;
    w_fetch     = 1'b0;
    w_wb        = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    case (r_state)
      S_IDLE: begin
        w_launch = w_start;
        if (w_start && (r_len != '0)) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        w_fetch = 1'b1;
        w_state_nxt = w_abort ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        busy   = 1'b1;
        alu_a  = r_rf[r_instr.srca];
        alu_b  = r_rf[r_instr.srcb];
        alu_op = r_instr.op;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wb = 1'b1;
          w_state_nxt = (!w_last || w_loop_again) ? S_FETCH : S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus writes to the register file cannot collide with writeback: the
  // former only land while idle, the latter only in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
      r_len         <= '0;
      r_latch       <= '0;
      r_wptr        <= '0;
      r_pc          <= '0;
      r_instr       <= '0;
      r_err         <= 1'b0;
      r_done_sticky <= 1'b0;
    end else begin
      if (w_wr_idle) begin
        case (bus.address)
          ADDR_R0, ADDR_R1, ADDR_R2, ADDR_R3: r_rf[bus.address[1:0]] <= DATA_W'(bus.data_in);
          ADDR_LEN:  r_len  <= sat_len(bus.data_in);
          ADDR_IHI:  r_wptr <= r_wptr + PC_W'(1);
          ADDR_WPTR: r_wptr <= '0;
          default: ;
        endcase
      end
      if (bus.data_write && (bus.address == ADDR_ILO)) r_latch <= bus.data_in;
      if (w_launch) begin
        r_pc          <= '0;
        r_err         <= (r_len == '0);
        r_done_sticky <= 1'b0;
      end
      if (w_fetch) r_instr <= w_slot;
      if (w_wb) begin
        if (op_supported(r_instr.op)) r_rf[r_instr.dst] <= alu_out;
        else                          r_err <= 1'b1;
        if (!w_last)           r_pc <= r_pc + PC_W'(1);
        else if (w_loop_again) r_pc <= '0;
      end
      if (r_state == S_DONE) r_done_sticky <= 1'b1;
    end
  end

`ifdef ACCEL_SEQ_LOOP_EN
  logic [7:0] r_loop_cnt;
  logic [7:0] r_loop_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loop_cnt <= '0;
      r_loop_rem <= '0;
    end else begin
      if (w_wr_idle && (bus.address == ADDR_LOOP)) r_loop_cnt <= bus.data_in;
      if (w_launch)                              r_loop_rem <= r_loop_cnt;
      else if (w_wb && w_last && w_loop_again)   r_loop_rem <= r_loop_rem - 8'd1;
    end
  end

  assign w_loop_again = (r_loop_rem != '0);
  assign w_loop_rd    = r_loop_cnt;
`else
  assign w_loop_again = 1'b0;
  assign w_loop_rd    = '0;
`endif

  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      ADDR_R0, ADDR_R1, ADDR_R2, ADDR_R3: bus.data_out = 8'(r_rf[bus.address[1:0]]);
      ADDR_CTRL: bus.data_out = {5'b0, r_err, r_done_sticky, busy};
      ADDR_LEN:  bus.data_out = 8'(r_len);
      ADDR_ILO:  bus.data_out = r_latch;
      ADDR_WPTR: bus.data_out = 8'(r_wptr);
      ADDR_PC:   bus.data_out = 8'(r_pc);
      ADDR_LOOP: bus.data_out = w_loop_rd;
      default:   bus.data_out = '0;
    endcase
  end

endmodule

// File: doc/accel_seq_ctrl.md
# accel_seq_ctrl

Micro-sequencer that runs a short stored program of ALU operations over the accelerator's four-entry 8-bit register file, so software can issue a whole chain of arithmetic with a single start write. It sits between the TinyQV peripheral bus (address/data_write/data_in/data_out) and the existing combinational ALU (a, b, op → out). It owns the register file and the program store, and drives the ALU operand and opcode inputs.

## Interface
- PROG_DEPTH, 8, program slots; power of two, 2..16
- DATA_W, 8, register file and ALU data width
- clk  in  1  project clock
- rst  in  1  synchronous, active-high reset
- address  in  4  bus register address
- data_write  in  1  bus write strobe; data_in valid when high
- data_in  in  8  bus write data
- data_out  out  8  combinational read data for `address`
- alu_a  out  DATA_W  ALU operand A
- alu_b  out  DATA_W  ALU operand B
- alu_op  out  4  ALU opcode
- alu_out  in  DATA_W  ALU result
- busy  out  1  high in FETCH and EXEC
- done  out  1  one-cycle pulse on program completion

## Operation
- Register map (reads are combinational):
  - 0x0–0x3: R0–R3, read/write.
  - 0x4: control. Write bit0 = start, bit1 = abort. Read {5'b0, err, done_sticky, busy}.
  - 0x5: program length. Read/write, 0..PROG_DEPTH.
  - 0x6: instruction low latch = {srcB[1:0], srcA[1:0], op[3:0]}.
  - 0x7: write {6'b0, dst[1:0]}. Commits {dst, latch} to slot[wptr], then wptr ← wptr+1 modulo PROG_DEPTH.
  - 0x8: wptr; any write clears it to 0.
  - 0x9: pc, read-only.
  - Other addresses read 0.
- FSM states: IDLE, FETCH, EXEC, DONE.
  - IDLE → FETCH on start with length ≠ 0; pc ← 0, done_sticky and err cleared.
  - FETCH: instr ← slot[pc].
  - EXEC: alu_a = R[srcA], alu_b = R[srcB], alu_op = op; R[dst] ← alu_out at the end of the cycle. Then pc+1 → FETCH, or → DONE after the last slot (pc = length−1).
  - DONE: done = 1, done_sticky ← 1, then → IDLE.
- Supported ops: ADD = 0x0, SUB = 0x1. Any other op is a NOP for writeback, sets err, and execution continues.
- Arithmetic wraps modulo 2^DATA_W.
- Source reads happen before destination writes, so dst = src is legal.
- Outside EXEC, alu_a, alu_b and alu_op are driven to 0.
- Boundary cases:
  - start with length 0: stays IDLE, err ← 1.
  - start while busy: ignored.
  - abort: takes effect at the next edge, returns to IDLE with no further writeback and no done pulse. If abort and start arrive in the same write, abort wins.
  - Bus writes to R0–R3, 0x5, 0x7 and 0x8 while busy are ignored.
  - A length larger than PROG_DEPTH is saturated to PROG_DEPTH when written.
- Reset: R0–R3, all program slots, latch, wptr, pc, length, err and done_sticky clear to 0. State → IDLE. busy = 0, done = 0. Reset mid-run aborts immediately.

## Timing
- The start write is sampled at edge E0. FETCH occupies E0→E1 and EXEC occupies E1→E2; R[dst] is updated at E2.
- Each instruction takes 2 cycles; busy stays high for exactly 2·length cycles.
- done pulses in the cycle after the last EXEC; busy is low in that cycle.
- A new start is accepted in the DONE cycle only after the FSM returns to IDLE, i.e. one cycle later.
- Bus reads of R0–R3 during a run return the current register value.

## Configuration
- ACCEL_SEQ_LOOP_EN defined: adds register 0xA, an 8-bit loop count. At the end of the last EXEC, if the remaining-loop counter ≠ 0, decrement it and set pc ← 0 instead of entering DONE. The program therefore runs count+1 times. The counter reloads from 0xA on start, and 0xA is read-only while busy.
- Macro undefined: 0xA reads 0, writes to it are ignored, and the program runs once.

## Structure
- Package accel_seq_pkg holds:
  - the opcode enum (ADD, SUB) and an `op_supported` helper;
  - the FSM state enum;
  - the register address localparams;
  - the packed instruction struct {dst, srcB, srcA, op}.
- Sub-module accel_seq_prog_mem: PROG_DEPTH × 10-bit store with one synchronous write port, one asynchronous read port, and a synchronous clear on rst.

## Test plan
- R0 = 5, R1 = 3; slot0 = ADD R0,R1→R2; length 1; start → busy high for 2 cycles, R2 = 8, one done pulse, status reads 0x02.
- R0 = 0xFF, R1 = 0x02; ADD R0,R1→R3 then SUB R1,R0→R2 → R3 = 0x01, R2 = 0x03.
- R0 = 10, R1 = 4; R2 = R0+R1; R3 = R2−R0; R0 = R3+R3 → R2 = 14, R3 = 4, R0 = 8, busy high for 6 cycles.
- 4-instruction program; abort written 3 cycles after start → only slot0's dst is written, no done pulse, busy low the following cycle.
- Slot0 op = 0x7, slot1 = ADD → slot0's dst unchanged, err = 1, slot1 result correct, done pulses.
- Start with length 0 → stays IDLE, status = 0x04. Assert rst mid-run → all registers read 0, busy = 0.
- With ACCEL_SEQ_LOOP_EN: loop = 2 and R0 = R0 + R1 with R0 = 0, R1 = 1 → R0 = 3, busy high for 6 cycles.
